// File: rtl/bit_gearbox_pkg.sv
// Shared helpers for the bit_gearbox width converter: level-counter sizing and the
// minimum-capacity rule checked at elaboration.
package bit_gearbox_pkg;

  // Extra bits required beyond IWIDTH+OWIDTH; zero means exactly one input plus one output word.
  localparam int unsigned BufMinSlack = 0;

  function automatic int unsigned level_width(int unsigned buf_bits);
    return $clog2(buf_bits + 1);
  endfunction

endpackage

// File: rtl/bit_gearbox_if.sv
// Ready/valid handshake bundle for bit_gearbox: input word stream and output word stream.
interface bit_gearbox_if #(
  parameter int unsigned IWIDTH = 3,
  parameter int unsigned OWIDTH = 7
);
  logic [IWIDTH-1:0] in;
  logic              in_valid;
  logic              in_ready;
  logic [OWIDTH-1:0] out;
  logic              out_valid;
  logic              out_ready;

  modport master (output in, in_valid, out_ready, input in_ready, out, out_valid);
  modport slave  (input in, in_valid, out_ready, output in_ready, out, out_valid);
endinterface

// File: rtl/bit_gearbox_shift_buffer.sv
// MSB-aligned bit buffer: oldest bit sits at the top, bits above the fill level are kept zero
// so a partial pop comes out left-justified with zero padding.
module bit_shift_buffer import bit_gearbox_pkg::*; #(
  parameter int unsigned IWIDTH   = 3,
  parameter int unsigned OWIDTH   = 7,
  parameter int unsigned BUF_BITS = IWIDTH + OWIDTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                push,
  input  logic [IWIDTH-1:0]                   push_data,
  input  logic                                pop,
  input  logic [level_width(BUF_BITS)-1:0]    pop_n,
  output logic [OWIDTH-1:0]                   rd_data,
  output logic [level_width(BUF_BITS)-1:0]    level
);
  localparam int unsigned LW = level_width(BUF_BITS);

  logic [BUF_BITS-1:0] buf_q, buf_d, popped, appended;
  logic [LW-1:0]       level_q, level_d, kept;

  always_comb begin
    kept     = pop ? level_q - pop_n : level_q;
    popped   = pop ? buf_q << pop_n : buf_q;
    // New bits land directly behind whatever survives the pop.
    appended = push ? ({push_data, {(BUF_BITS - IWIDTH){1'b0}}} >> kept) : '0;
    buf_d    = popped | appended;
    level_d  = kept + (push ? LW'(IWIDTH) : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q   <= '0;
      level_q <= '0;
    end else begin
      buf_q   <= buf_d;
      level_q <= level_d;
    end
  end

  assign rd_data = buf_q[BUF_BITS-1 -: OWIDTH];
  assign level   = level_q;

endmodule

// File: rtl/bit_gearbox.sv
// Packs IWIDTH-bit input words into OWIDTH-bit output words, MSB-first, with ready/valid on
// both sides. Define BIT_GEARBOX_FLUSH_EN to add the flush port for draining a partial word.
module bit_gearbox import bit_gearbox_pkg::*; #(
  parameter int unsigned IWIDTH   = 3,
  parameter int unsigned OWIDTH   = 7,
  parameter int unsigned BUF_BITS = IWIDTH + OWIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
`ifdef BIT_GEARBOX_FLUSH_EN
  input  logic                             flush,
`endif
  bit_gearbox_if.slave                     bus,
  output logic [level_width(BUF_BITS)-1:0] level
);
  localparam int unsigned LW = level_width(BUF_BITS);

  if (BUF_BITS < IWIDTH + OWIDTH + BufMinSlack) begin : g_buf_check
    $error("bit_gearbox: BUF_BITS must be >= IWIDTH + OWIDTH");
  end

  logic flush_req;
`ifdef BIT_GEARBOX_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  logic              in_ready, acc, free, full_word, ld_full, ld_flush, ld;
  logic [LW-1:0]     pop_n;
  logic [OWIDTH-1:0] rd_data;
  logic [OWIDTH-1:0] out_q;
  logic              out_valid_q;

  always_comb begin
    full_word = 32'(level) >= OWIDTH;
    // Held low during reset so nothing upstream sees a spurious ready.
    in_ready  = rst_n & en & ((32'(level) + IWIDTH) <= BUF_BITS) & ~flush_req;
    acc       = bus.in_valid & in_ready;
    free      = ~out_valid_q | bus.out_ready;
    ld_full   = en & full_word & free;
    ld_flush  = en & flush_req & (level != '0) & ~full_word & free;
    ld        = ld_full | ld_flush;
    pop_n     = ld_full ? LW'(OWIDTH) : level;
  end

  bit_shift_buffer #(
    .IWIDTH   (IWIDTH),
    .OWIDTH   (OWIDTH),
    .BUF_BITS (BUF_BITS)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (acc),
    .push_data (bus.in),
    .pop       (ld),
    .pop_n     (pop_n),
    .rd_data   (rd_data),
    .level     (level)
  );

  // Output stage drains on out_ready regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (ld) begin
      out_q       <= rd_data;
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_bit_gearbox.sv
// Self-checking bench for bit_gearbox: bit-queue reference model, per-cycle compare,
// directed literal checks and a randomized soak.
module tb_bit_gearbox;
  localparam int IW = 3;
  localparam int OW = 7;
  localparam int BB = 10;
`ifdef BIT_GEARBOX_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       fl;
  logic [3:0] level;

  bit_gearbox_if #(.IWIDTH(IW), .OWIDTH(OW)) bus ();

  bit_gearbox #(.IWIDTH(IW), .OWIDTH(OW), .BUF_BITS(BB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
`ifdef BIT_GEARBOX_FLUSH_EN
    .flush (fl),
`endif
    .bus   (bus),
    .level (level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of stream bits plus the output word.
  bit          bq[$];
  logic [OW-1:0] m_out;
  bit          m_valid;
  int          n_acc, c3, cyc;

  function automatic bit m_in_ready();
    return rst_n && en && (bq.size() + IW <= BB) && !fl;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        bq.delete();
        m_out = '0; m_valid = 0; n_acc = 0; c3 = -1; cyc = 0;
      end else begin
        automatic int sz   = bq.size();
        automatic bit acc  = bus.in_valid && m_in_ready();
        automatic bit free = !m_valid || bus.out_ready;
        cyc++;
        if (en && sz >= OW && free) begin
          for (int i = 0; i < OW; i++) m_out[OW-1-i] = bq.pop_front();
          m_valid = 1;
        end else if (FLUSH_EN && en && fl && sz > 0 && free) begin
          m_out = '0;
          for (int i = 0; i < sz; i++) m_out[OW-1-i] = bq.pop_front();
          m_valid = 1;
        end else if (bus.out_ready) begin
          m_valid = 0;
        end
        if (acc) begin
          for (int i = 0; i < IW; i++) bq.push_back(bus.in[IW-1-i]);
          n_acc++;
          if (n_acc == 3) c3 = cyc;
        end
      end
    end
  end

  // Compare process: every negedge, DUT against model; also logs delivered words.
  int          first_ov = -1;
  logic [OW-1:0] olog[$];

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        first_ov = -1;
        olog.delete();
      end
      check("out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("out", 32'(bus.out), 32'(m_out));
      check("level", 32'(level), bq.size());
      check("in_ready", 32'(bus.in_ready), 32'(m_in_ready()));
      if (rst_n && bus.out_valid && first_ov < 0) first_ov = cyc;
      if (rst_n && bus.out_valid && bus.out_ready) olog.push_back(bus.out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    bus.in_valid = 0; bus.out_ready = 0; bus.in = '0; fl = 0; en = 0;
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    en = 1;
  endtask

  task automatic fill_backpressure();
    do_reset();
    bus.in = 3'b101; bus.in_valid = 1;
    repeat (12) tick();
  endtask

  logic [OW-1:0] exp_words[3];

  initial begin
    exp_words[0] = 7'b1011011;
    exp_words[1] = 7'b0110110;
    exp_words[2] = 7'b1101101;
    bus.in_valid = 0; bus.out_ready = 0; bus.in = '0; fl = 0; en = 0; rst_n = 0;
    repeat (2) tick();
    check("rst_out", 32'(bus.out), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_level", 32'(level), 0);
    en = 1;
    #1 check("rst_in_ready_low", 32'(bus.in_ready), 0);
    rst_n = 1;
    #1 check("release_in_ready", 32'(bus.in_ready), 1);

    // Invalid input leaves everything idle.
    repeat (10) tick();
    check("idle_level", 32'(level), 0);
    check("idle_out_valid", 32'(bus.out_valid), 0);

    // Stream packing with a free consumer.
    do_reset();
    bus.out_ready = 1; bus.in = 3'b101; bus.in_valid = 1;
    for (int i = 0; i < 50 && n_acc < 7; i++) tick();
    bus.in_valid = 0;
    check("stream_accepts", n_acc, 7);
    repeat (4) tick();
    check("stream_words", olog.size(), 3);
    for (int i = 0; i < 3; i++)
      check("stream_word", (i < olog.size()) ? 32'(olog[i]) : 32'hffff_ffff, 32'(exp_words[i]));
    check("stream_level", 32'(level), 0);
    check("stream_latency", first_ov - c3, 1);

    // Backpressure: buffer fills to 8 bits behind a held word.
    fill_backpressure();
    check("bp_accepts", n_acc, 5);
    check("bp_out", 32'(bus.out), 32'(exp_words[0]));
    check("bp_out_valid", 32'(bus.out_valid), 1);
    check("bp_in_ready", 32'(bus.in_ready), 0);
    check("bp_level", 32'(level), 8);
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
    check("bp_reassert", 32'(bus.in_ready), 1);
    check("bp_next_word", 32'(bus.out), 32'(exp_words[1]));

    // Asynchronous reset while out_valid is high.
    rst_n = 0;
    #1;
    check("midrst_out", 32'(bus.out), 0);
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_level", 32'(level), 0);
    check("midrst_in_ready", 32'(bus.in_ready), 0);
    tick();
    check("midrst_in_ready_hold", 32'(bus.in_ready), 0);
    rst_n = 1;

    // Enable freeze: drain the output with en=0, then re-enable.
    fill_backpressure();
    en = 0; bus.in_valid = 0; bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
    repeat (3) tick();
    check("frz_level", 32'(level), 8);
    check("frz_out_valid", 32'(bus.out_valid), 0);
    en = 1;
    tick();
    check("frz_load_valid", 32'(bus.out_valid), 1);
    check("frz_load_out", 32'(bus.out), 32'(exp_words[1]));
    check("frz_load_level", 32'(level), 1);

`ifdef BIT_GEARBOX_FLUSH_EN
    do_reset();
    bus.in = 3'b101; bus.in_valid = 1;
    for (int i = 0; i < 20 && n_acc < 2; i++) tick();
    bus.in_valid = 0;
    fl = 1;
    #1 check("fl_in_ready", 32'(bus.in_ready), 0);
    tick();
    check("fl_out", 32'(bus.out), 32'(7'b1011010));
    check("fl_out_valid", 32'(bus.out_valid), 1);
    check("fl_level", 32'(level), 0);
    check("fl_in_ready_hold", 32'(bus.in_ready), 0);
    fl = 0;
`endif

    // Randomized soak against the model.
    do_reset();
    repeat (3000) begin
      en            = ($urandom_range(0, 9) != 0);
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in        = IW'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      fl            = FLUSH_EN && ($urandom_range(0, 19) == 0);
      tick();
    end
    bus.in_valid = 0; fl = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
